// File: rtl/rst_seq.sv
// rst_seq: staged reset sequencer.
//
// Holds every reset output for 2^HOLD_W cycles, then releases them one at a
// time, lowest bit first, STAGE_GAP cycles apart. A debounced button rising
// edge, a software request or (optionally) a CPU trap restarts the whole
// sequence from a full hold and records the cause.
//
// Optional feature: define RST_SEQ_TRAP_EN to make a trap_i rising edge seen
// in RUN a reset event (cause 11). Without it trap_i is ignored.
//
// Ports
//   clk          - single clock, all logic on the rising edge
//   rst          - synchronous active-high power-on/global reset
//   btn_i        - asynchronous reset button, active high
//   sw_rst_req_i - software reset request, sampled every cycle
//   trap_i       - CPU trap flag (level)
//   rst_o        - staged reset outputs, active high
//   ready_o      - high once every stage has been released
//   cause_o      - last reset cause: 00 por, 01 button, 10 software, 11 trap
module rst_seq #(
    parameter int unsigned N_OUT     = 2,
    parameter int unsigned HOLD_W    = 16,
    parameter int unsigned STAGE_GAP = 16,
    parameter int unsigned DEBOUNCE  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_i,
    input  logic             sw_rst_req_i,
    input  logic             trap_i,
    output logic [N_OUT-1:0] rst_o,
    output logic             ready_o,
    output logic [1:0]       cause_o
);

    localparam int unsigned GapW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int unsigned KW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned DbW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [GapW-1:0] GapReload = GapW'(STAGE_GAP - 1);
    localparam logic [KW-1:0]   KLast     = KW'(N_OUT - 1);
    localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE - 1);

    localparam logic [1:0] CausePor  = 2'b00;
    localparam logic [1:0] CauseBtn  = 2'b01;
    localparam logic [1:0] CauseSw   = 2'b10;
    localparam logic [1:0] CauseTrap = 2'b11;

    typedef enum logic [1:0] {StHold, StRelease, StRun} state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [KW-1:0]     k_q, k_d;
    logic [N_OUT-1:0]  stage_q, stage_d;
    logic              ready_q, ready_d;
    logic [1:0]        cause_q, cause_d;

    logic              sync1_q, sync2_q;
    logic              btn_db_q, btn_db_d, btn_db_prev_q;
    logic [DbW-1:0]    db_cnt_q, db_cnt_d;

    logic              btn_evt, sw_evt, trap_evt;

    // Debouncer: accept the synchronized level only after it has differed from
    // the current debounced level for DEBOUNCE consecutive cycles.
    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == DbLast) begin
                btn_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign btn_evt = btn_db_q & ~btn_db_prev_q;
    assign sw_evt  = sw_rst_req_i;

`ifdef RST_SEQ_TRAP_EN
    logic trap_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trap_prev_q <= 1'b0;
        end else begin
            trap_prev_q <= trap_i;
        end
    end

    // Trap edges outside RUN are dropped: a sequence already in progress wins.
    assign trap_evt = trap_i & ~trap_prev_q & (state_q == StRun);
`else
    logic unused_trap;
    assign unused_trap = trap_i;
    assign trap_evt    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        k_d     = k_q;
        stage_d = stage_q;
        ready_d = ready_q;
        cause_d = cause_q;

        unique case (state_q)
            StHold: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (!btn_db_q) begin
                    // A button still held down keeps the system parked here.
                    state_d = StRelease;
                    gap_d   = GapReload;
                    k_d     = '0;
                end
            end
            StRelease: begin
                if (gap_q == '0) begin
                    stage_d[k_q] = 1'b0;
                    gap_d        = GapReload;
                    if (k_q == KLast) begin
                        state_d = StRun;
                        ready_d = 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            StRun: begin
            end
            default: begin
                state_d = StHold;
            end
        endcase

        // Any event restarts from a full hold regardless of progress.
        if (btn_evt || sw_evt || trap_evt) begin
            state_d = StHold;
            hold_d  = '1;
            k_d     = '0;
            stage_d = '1;
            ready_d = 1'b0;
            if (btn_evt) begin
                cause_d = CauseBtn;
            end else if (sw_evt) begin
                cause_d = CauseSw;
            end else begin
                cause_d = CauseTrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StHold;
            hold_q        <= '1;
            gap_q         <= GapReload;
            k_q           <= '0;
            stage_q       <= '1;
            ready_q       <= 1'b0;
            cause_q       <= CausePor;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            db_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            gap_q         <= gap_d;
            k_q           <= k_d;
            stage_q       <= stage_d;
            ready_q       <= ready_d;
            cause_q       <= cause_d;
            sync1_q       <= btn_i;
            sync2_q       <= sync1_q;
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_q;
            db_cnt_q      <= db_cnt_d;
        end
    end

    assign rst_o   = stage_q;
    assign ready_o = ready_q;
    assign cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with N_OUT=3, HOLD_W=4, STAGE_GAP=3, DEBOUNCE=4.
// Edge numbering: edge 0 is the last edge that samples rst (or an event) high;
// stage k then clears at edge 16 + 3*(k+1), i.e. 19/22/25.
module tb_rst_seq;

    logic       clk;
    logic       rst;
    logic       btn_i;
    logic       sw_rst_req_i;
    logic       trap_i;
    logic [2:0] rst_o;
    logic       ready_o;
    logic [1:0] cause_o;

    int n_checks = 0;
    int n_fail   = 0;

    rst_seq #(
        .N_OUT    (3),
        .HOLD_W   (4),
        .STAGE_GAP(3),
        .DEBOUNCE (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_i       (btn_i),
        .sw_rst_req_i(sw_rst_req_i),
        .trap_i      (trap_i),
        .rst_o       (rst_o),
        .ready_o     (ready_o),
        .cause_o     (cause_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        logic [2:0] exp_rst;
        rst = 1'b1; btn_i = 1'b0; sw_rst_req_i = 1'b0; trap_i = 1'b0;
        ticks(2);
        n_checks++;
        if (rst_o !== 3'b111) begin
            n_fail++; $display("FAIL reset_rst_o got %b want 111", rst_o);
        end
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got %b want 0", ready_o);
        end
        n_checks++;
        if (cause_o !== 2'b00) begin
            n_fail++; $display("FAIL reset_cause got %b want 00", cause_o);
        end
        rst = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            tick();
            exp_rst[0] = (e < 19);
            exp_rst[1] = (e < 22);
            exp_rst[2] = (e < 25);
            n_checks++;
            if (rst_o !== exp_rst || ready_o !== (e >= 25)) begin
                n_fail++;
                $display("FAIL por_seq edge %0d got rst_o=%b ready=%b want rst_o=%b ready=%b",
                         e, rst_o, ready_o, exp_rst, (e >= 25));
            end
        end
        n_checks++;
        if (cause_o !== 2'b00) begin
            n_fail++; $display("FAIL por_cause got %b want 00", cause_o);
        end
    endtask

    task automatic test_sw_reset();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        n_checks++;
        if (rst_o !== 3'b111 || ready_o !== 1'b0 || cause_o !== 2'b10) begin
            n_fail++;
            $display("FAIL sw_event got rst_o=%b ready=%b cause=%b want 111 0 10",
                     rst_o, ready_o, cause_o);
        end
        for (int i = 1; i <= 25; i++) begin
            tick();
            n_checks++;
            if (ready_o !== (i == 25)) begin
                n_fail++;
                $display("FAIL sw_ready edge +%0d got %b want %b", i, ready_o, (i == 25));
            end
        end
    endtask

    task automatic test_btn_glitch();
        btn_i = 1'b1;
        ticks(3);
        btn_i = 1'b0;
        ticks(12);
        n_checks++;
        if (rst_o !== 3'b000 || ready_o !== 1'b1 || cause_o !== 2'b10) begin
            n_fail++;
            $display("FAIL btn_glitch got rst_o=%b ready=%b cause=%b want 000 1 10",
                     rst_o, ready_o, cause_o);
        end
    endtask

    task automatic test_btn_hold();
        btn_i = 1'b1;
        // 2 sync edges + 4 debounce edges, event lands on the 7th edge.
        ticks(6);
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL btn_early got ready=%b want 1", ready_o);
        end
        tick();
        n_checks++;
        if (rst_o !== 3'b111 || ready_o !== 1'b0 || cause_o !== 2'b01) begin
            n_fail++;
            $display("FAIL btn_event got rst_o=%b ready=%b cause=%b want 111 0 01",
                     rst_o, ready_o, cause_o);
        end
        ticks(30);
        n_checks++;
        if (rst_o !== 3'b111 || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL btn_held got rst_o=%b ready=%b want 111 0", rst_o, ready_o);
        end
        btn_i = 1'b0;
        // Debounced low at +6, RELEASE at +7, first stage clears at +10.
        ticks(9);
        n_checks++;
        if (rst_o !== 3'b111) begin
            n_fail++; $display("FAIL btn_rel9 got %b want 111", rst_o);
        end
        tick();
        n_checks++;
        if (rst_o !== 3'b110) begin
            n_fail++; $display("FAIL btn_rel10 got %b want 110", rst_o);
        end
        ticks(6);
        n_checks++;
        if (rst_o !== 3'b000 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL btn_ready got rst_o=%b ready=%b want 000 1", rst_o, ready_o);
        end
    endtask

    task automatic test_release_restart();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        ticks(18);
        n_checks++;
        if (rst_o !== 3'b111) begin
            n_fail++; $display("FAIL rr_e18 got %b want 111", rst_o);
        end
        tick();
        n_checks++;
        if (rst_o !== 3'b110) begin
            n_fail++; $display("FAIL rr_e19 got %b want 110", rst_o);
        end
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        n_checks++;
        if (rst_o !== 3'b111 || cause_o !== 2'b10) begin
            n_fail++;
            $display("FAIL rr_restart got rst_o=%b cause=%b want 111 10", rst_o, cause_o);
        end
        ticks(18);
        n_checks++;
        if (rst_o !== 3'b111) begin
            n_fail++; $display("FAIL rr_hold18 got %b want 111", rst_o);
        end
        tick();
        n_checks++;
        if (rst_o !== 3'b110) begin
            n_fail++; $display("FAIL rr_hold19 got %b want 110", rst_o);
        end
        ticks(6);
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rr_ready got %b want 1", ready_o);
        end
    endtask

    task automatic test_trap();
`ifdef RST_SEQ_TRAP_EN
        trap_i = 1'b1;
        tick();
        n_checks++;
        if (rst_o !== 3'b111 || cause_o !== 2'b11) begin
            n_fail++;
            $display("FAIL trap_event got rst_o=%b cause=%b want 111 11", rst_o, cause_o);
        end
        // A trap edge during HOLD must not restart the sequence.
        trap_i = 1'b0;
        tick();
        trap_i = 1'b1;
        tick();
        ticks(23);
        n_checks++;
        if (ready_o !== 1'b1 || cause_o !== 2'b11) begin
            n_fail++;
            $display("FAIL trap_hold_ignored got ready=%b cause=%b want 1 11", ready_o, cause_o);
        end
        trap_i = 1'b0;
        tick();
        btn_i = 1'b1;
        ticks(6);
        trap_i = 1'b1;
        tick();
        n_checks++;
        if (rst_o !== 3'b111 || cause_o !== 2'b01) begin
            n_fail++;
            $display("FAIL trap_btn_prio got rst_o=%b cause=%b want 111 01", rst_o, cause_o);
        end
        btn_i = 1'b0;
        trap_i = 1'b0;
        ticks(25);
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL trap_ready got %b want 1", ready_o);
        end
`else
        for (int i = 0; i < 6; i++) begin
            trap_i = ~trap_i;
            tick();
        end
        trap_i = 1'b0;
        tick();
        n_checks++;
        if (rst_o !== 3'b000 || ready_o !== 1'b1 || cause_o !== 2'b10) begin
            n_fail++;
            $display("FAIL trap_ignored got rst_o=%b ready=%b cause=%b want 000 1 10",
                     rst_o, ready_o, cause_o);
        end
`endif
    endtask

    task automatic test_rst_mid_release();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        ticks(19);
        n_checks++;
        if (rst_o !== 3'b110 || cause_o !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_pre got rst_o=%b cause=%b want 110 10", rst_o, cause_o);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (rst_o !== 3'b111 || ready_o !== 1'b0 || cause_o !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_rst got rst_o=%b ready=%b cause=%b want 111 0 00",
                     rst_o, ready_o, cause_o);
        end
        rst = 1'b0;
        ticks(18);
        n_checks++;
        if (rst_o !== 3'b111) begin
            n_fail++; $display("FAIL mid_e18 got %b want 111", rst_o);
        end
        // Bit 0 clearing first shows the stage index restarted at 0.
        tick();
        n_checks++;
        if (rst_o !== 3'b110) begin
            n_fail++; $display("FAIL mid_e19 got %b want 110", rst_o);
        end
    endtask

    initial begin
        test_reset();
        test_sw_reset();
        test_btn_glitch();
        test_btn_hold();
        test_release_restart();
        test_trap();
        test_rst_mid_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter N_OUT, default 2, the number of staged reset outputs (1..8).
REQ-002 SHALL have parameter HOLD_W, default 16, the hold counter width; the hold lasts 2^HOLD_W cycles.
REQ-003 SHALL have parameter STAGE_GAP, default 16, the cycles between successive stage releases (>=1).
REQ-004 SHALL have parameter DEBOUNCE, default 8, the consecutive stable cycles needed to accept a button change (>=1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; one clock, and all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset is synchronous and active-high (power-on/global).
REQ-007 SHALL have port btn_i, input, 1 bit: asynchronous reset button, active high.
REQ-008 SHALL have port sw_rst_req_i, input, 1 bit: software reset request, sampled every cycle.
REQ-009 SHALL have port trap_i, input, 1 bit: CPU trap flag, level.
REQ-010 SHALL have port rst_o, output, N_OUT bits: staged reset outputs, active high.
REQ-011 SHALL have port ready_o, output, 1 bit: all stages released.
REQ-012 SHALL have port cause_o, output, 2 bits: last reset cause (00 por, 01 button, 10 software, 11 trap).

Function
REQ-013 SHALL pass btn_i through a 2-FF synchronizer, then a debouncer; debounced level btn_db changes only after the synchronized input differs from btn_db for DEBOUNCE consecutive cycles.
REQ-014 SHALL implement states HOLD, RELEASE and RUN.
REQ-015 HOLD: hold counter decrements by 1 per cycle, saturating at 0; all rst_o bits =1; ready_o=0.
REQ-016 HOLD->RELEASE when counter==0 and btn_db==0; with btn_db==1, stay in HOLD at 0.
REQ-017 On RELEASE entry, load gap counter with STAGE_GAP-1 and set stage index k=0.
REQ-018 RELEASE: gap decrements each cycle; when gap==0, clear rst_o[k], increment k and reload STAGE_GAP-1.
REQ-019 Stage release order SHALL be ascending (bit 0 first); released bits stay 0 until the next reset event.
REQ-020 Clearing rst_o[N_OUT-1] SHALL move to RUN and set ready_o=1 on that same edge.
REQ-021 Reset event = btn_db rising edge, or sw_rst_req_i==1, or trap event (REQ-030).
REQ-022 A reset event in any state SHALL, on the next edge: set all rst_o=1, ready_o=0, load hold counter to 2^HOLD_W-1, enter HOLD, and update cause_o.
REQ-023 Simultaneous events: cause priority SHALL be button > software > trap.
REQ-024 An event during HOLD/RELEASE SHALL restart the sequence from full hold (no merge, no partial release).
REQ-025 Timing: with rst low from edge 1, rst_o[k] SHALL clear at edge 2^HOLD_W + (k+1)*STAGE_GAP.

Reset
REQ-026 rst=1 SHALL force: state HOLD, hold counter =2^HOLD_W-1, all rst_o=1, ready_o=0, cause_o=00, synchronizer and debouncer =0, btn_db=0, k=0.
REQ-027 rst SHALL override all other inputs, including in mid-RELEASE.
REQ-028 All outputs SHALL be registered; no combinational path from any input to any output.

Configuration
REQ-029 Macro RST_SEQ_TRAP_EN SHALL control the trap-triggered reset feature.
REQ-030 Defined: a trap_i rising edge (registered previous value) while in RUN is a reset event with cause 11; a trap_i edge in HOLD/RELEASE is ignored.
REQ-031 Undefined: trap_i port present but ignored; cause_o never reports 11.

Verification (N_OUT=3, HOLD_W=4, STAGE_GAP=3, DEBOUNCE=4)
REQ-032 rst high 2 cycles then low -> rst_o[0]/[1]/[2] clear at edges 19/22/25; ready_o=1 at edge 25; cause_o=00.
REQ-033 In RUN, sw_rst_req_i pulsed 1 cycle -> next edge rst_o=111, ready_o=0, cause_o=10; ready_o=1 again 25 edges later.
REQ-034 In RUN, btn_i glitch high 3 cycles -> no event; btn_i held 10 cycles -> event with cause_o=01; btn_i held through HOLD end -> counter stays 0 until release.
REQ-035 In RELEASE after rst_o[0] cleared, sw_rst_req_i=1 -> rst_o=111, full 16-cycle hold restarts.
REQ-036 With macro: trap_i 0->1 in RUN -> cause_o=11 reset; with btn event same cycle -> cause_o=01. Without macro: trap_i toggles -> no change.
REQ-037 rst asserted at edge 20 (mid-RELEASE) -> next edge rst_o=111, cause_o=00, k=0.
